// File: rtl/fdce_fdpe_pkg.sv
// fdce_fdpe_pkg
// Shared constants and helpers for the fdce_fdpe register bank.
//   FD_MODE_CLR / FD_MODE_PRE : per-bit reset personality used to build
//                               PRESET_MASK values (0 = clear-type, 1 = preset-type)
//   FD_MAX_WIDTH              : widest mask the replicate helper can build
//   fdReplicate()             : copies a mode bit into the low 'width' bits
package fdce_fdpe_pkg;

  localparam logic FD_MODE_CLR = 1'b0;
  localparam logic FD_MODE_PRE = 1'b1;

  localparam int FD_MAX_WIDTH = 64;

  // Builds a mask with the low 'width' bits set to 'mode' and the rest zero.
  // The caller casts the result down to its own WIDTH.
  function automatic logic [FD_MAX_WIDTH-1:0] fdReplicate(input logic mode, input int width);
    logic [FD_MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < FD_MAX_WIDTH; i++) begin
      if (i < width) begin
        r[i] = mode;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fdce_fdpe_fd_cell.sv
// fd_cell
// One D flip-flop with clock enable and a synchronous reset whose reset
// value is fixed by the PRESET parameter (0 behaves like FDCE, 1 like FDPE).
// Ports:
//   clk : rising-edge clock
//   clr : synchronous active-high reset, wins over ce
//   ce  : clock enable
//   d   : data input
//   q   : registered output
// Parameters:
//   INIT   : power-up value before the first clock edge
//   PRESET : value loaded while clr is high
module fd_cell
  import fdce_fdpe_pkg::*;
#(
  parameter logic INIT   = FD_MODE_CLR,
  parameter logic PRESET = FD_MODE_CLR
) (
  input  logic clk,
  input  logic clr,
  input  logic ce,
  input  logic d,
  output logic q
);

  // The declaration initializer gives the power-up value; clr never
  // restores it, it always loads PRESET instead.
  logic q_q = INIT;
  logic q_d;

  // Next state: clr first, then an enabled load, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = PRESET;
    end else if (ce) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/fdce_fdpe.sv
// fdce_fdpe
// Portable register bank replacing rows of FDCE/FDPE primitives. Every bit
// is an independent flop with its own clock enable; on clr each bit loads
// its PRESET_MASK bit. Reset is synchronous, so clr pulses that miss a
// rising edge are ignored.
// Ports:
//   clk : rising-edge clock
//   clr : synchronous active-high reset, priority over ce
//   ce  : per-bit clock enable, WIDTH bits
//   d   : data input, WIDTH bits
//   q   : registered output, WIDTH bits
// Parameters:
//   WIDTH       : number of flops (>= 1)
//   PRESET_MASK : reset value, bit i = 1 makes flop i preset-type
//   INIT        : power-up value before the first edge
module fdce_fdpe
  import fdce_fdpe_pkg::*;
#(
  parameter int WIDTH       = 8,
  // Left untyped so an oversized override keeps its real width and can be
  // caught below instead of being silently truncated.
  parameter     PRESET_MASK = {WIDTH{FD_MODE_CLR}},
  parameter     INIT        = {WIDTH{FD_MODE_CLR}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] PRESET_W = WIDTH'(PRESET_MASK);
  localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(INIT);

  // Configuration checks, resolved at elaboration.
  if (WIDTH < 1) begin : g_err_width
    $fatal(1, "fdce_fdpe: WIDTH must be at least 1");
  end
  if ($bits(PRESET_MASK) > WIDTH) begin : g_err_preset
    $fatal(1, "fdce_fdpe: PRESET_MASK is wider than WIDTH");
  end
  if ($bits(INIT) > WIDTH) begin : g_err_init
    $fatal(1, "fdce_fdpe: INIT is wider than WIDTH");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fd_cell #(
      .INIT   (INIT_W[i]),
      .PRESET (PRESET_W[i])
    ) u_cell (
      .clk (clk),
      .clr (clr),
      .ce  (ce[i]),
      .d   (d[i]),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_fdce_fdpe.sv
// tb_fdce_fdpe
// Self-checking bench for fdce_fdpe. Two instances share clr/ce/d: an
// 8-bit bank (INIT = A5, PRESET_MASK = F0) and a 1-bit preset-type bank.
// A driver issues one stimulus per clock, updates a reference model and
// queues the expected q values; a monitor pops and compares them on the
// falling edge after each rising edge.
module tb_fdce_fdpe;
  import fdce_fdpe_pkg::*;

  localparam logic [7:0] INIT8  = 8'hA5;
  localparam logic [7:0] PMASK8 = 8'hF0;
  localparam logic       INIT1  = 1'b0;
  localparam logic       PMASK1 = 1'(fdReplicate(FD_MODE_PRE, 1));

  typedef struct packed {
    logic [7:0] q8;
    logic       q1;
  } expT;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] ce  = 8'h00;
  logic [7:0] d   = 8'h00;
  logic [7:0] q8;
  logic [0:0] q1;

  logic [7:0] model8 = INIT8;
  logic       model1 = INIT1;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;
  bit  started = 1'b0;

  fdce_fdpe #(
    .WIDTH       (8),
    .PRESET_MASK (PMASK8),
    .INIT        (INIT8)
  ) dut8 (
    .clk (clk),
    .clr (clr),
    .ce  (ce),
    .d   (d),
    .q   (q8)
  );

  fdce_fdpe #(
    .WIDTH       (1),
    .PRESET_MASK (PMASK1),
    .INIT        (INIT1)
  ) dut1 (
    .clk (clk),
    .clr (clr),
    .ce  (ce[0:0]),
    .d   (d[0:0]),
    .q   (q1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) started = 1'b1;

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Drives one cycle of inputs and records what q must show after the edge.
  task automatic applyStimulus(input logic c, input logic [7:0] e, input logic [7:0] dv);
    clr = c;
    ce  = e;
    d   = dv;
    if (c) begin
      model8 = PMASK8;
      model1 = PMASK1;
    end else begin
      model8 = (model8 & ~e) | (dv & e);
      model1 = e[0] ? dv[0] : model1;
    end
    expQ.push_back('{q8: model8, q1: model1});
    @(posedge clk);
    #1;
  endtask

  // clr pulse that rises and falls between two rising edges, nothing enabled.
  task automatic applyGlitch();
    ce  = 8'h00;
    d   = 8'($urandom);
    clr = 1'b1;
    #2;
    clr = 1'b0;
    expQ.push_back('{q8: model8, q1: model1});
    @(posedge clk);
    #1;
  endtask

  // Monitor: each falling edge after the first rising edge checks one result.
  always @(negedge clk) begin
    if (started && expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      checkOutput("q8", q8, e.q8);
      checkOutput("q1", {7'b0, q1}, {7'b0, e.q1});
    end
  end

  // Driver.
  initial begin
    #1;
    checkOutput("powerup_q8", q8, INIT8);
    checkOutput("powerup_q1", {7'b0, q1}, {7'b0, INIT1});

    // Power-up hold: no clr, no enable.
    repeat (3) applyStimulus(1'b0, 8'h00, 8'($urandom));

    // Reset, then clr held while trying to load.
    applyStimulus(1'b1, 8'h00, 8'h00);
    repeat (4) applyStimulus(1'b1, 8'hFF, 8'h0F);

    // Loads after reset.
    applyStimulus(1'b0, 8'hFF, 8'h3C);
    applyStimulus(1'b0, 8'h01, 8'hFF);

    // clr beats a full enable.
    applyStimulus(1'b1, 8'hFF, 8'h00);

    // Release with only the low nibble enabled.
    applyStimulus(1'b0, 8'h0F, 8'h55);

    // Short clr pulse between edges.
    applyGlitch();
    applyStimulus(1'b0, 8'h00, 8'h00);

    // Randomized traffic, clr roughly one cycle in eight.
    for (int i = 0; i < 150; i++) begin
      applyStimulus(($urandom_range(0, 7) == 0), 8'($urandom), 8'($urandom));
    end
    applyStimulus(1'b0, 8'h00, 8'h00);

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
